uart_tx_arbiter: RTL and testbench

- Shares one usart_tx byte transmitter among N_REQ requesters, such as a debug console, a status reporter and a DMA log.
- Uses round-robin arbitration with packet locking: a grant stays with one requester until its last byte is accepted, a burst limit is reached, or the requester stalls too long.
- Inserts a programmable idle gap between packets so the receiver can resynchronise.
- Sits directly between the requester byte streams and the usart_tx data handshake.

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the usart_tx arbiter: FSM state encoding,
// release-cause type and the requester index width helper.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   typedef enum logic [1:0] {
      REL_NONE,
      REL_LAST,
      REL_BURST,
      REL_STALL
   } rel_cause_e;

   // A single requester index still needs one bit so ports never collapse to zero width.
   function automatic int calc_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// ptr_i, wrapping modulo N. Usable by any shared peripheral.
module uart_tx_arbiter_rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [ID_W-1:0] win_o,
   output logic            any_o
);

   logic [N-1:0]    rot;
   logic [ID_W-1:0] off;
   logic [ID_W:0]   sum;

   // Rotate so that bit 0 of rot corresponds to requester ptr_i.
   assign rot = (req_i >> ptr_i) | (req_i << ((ID_W+1)'(N) - {1'b0, ptr_i}));

   always_comb begin
      off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = ID_W'(k);
         end
      end
   end

   assign sum   = {1'b0, ptr_i} + {1'b0, off};
   assign win_o = ID_W'((sum >= (ID_W+1)'(N)) ? sum - (ID_W+1)'(N) : sum);
   assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one usart_tx byte transmitter among N_REQ requesters with
// round-robin packet locking, burst limit, stall timeout and idle gap.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int  N_REQ         = 4,
   parameter int  MAX_BURST     = 64,
   parameter int  GAP_CYCLES    = 0,
   parameter int  STALL_TIMEOUT = 1024,
   localparam int ID_W          = calc_id_w(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_data_valid,
   input  logic                 tx_data_ready,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic                 burst_cut,
   output logic                 stall_abort
);

   localparam int STALL_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT);

   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               grant_valid_q, grant_valid_d;
   logic [15:0]        byte_cnt_q, byte_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [15:0]        gap_cnt_q, gap_cnt_d;
   logic               burst_cut_q, burst_cut_d;
   logic               stall_abort_q, stall_abort_d;

   logic [7:0]         req_byte [N_REQ];
   logic               is_xfer;
   logic               g_valid;
   logic               g_last;
   logic               accept;
   logic [ID_W-1:0]    pick_win;
   logic               pick_any;
   rel_cause_e         rel_cause;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_byte[gi]  = req_data[8*gi +: 8];
      assign req_ready[gi] = is_xfer && (grant_id_q == ID_W'(gi)) && tx_data_ready;
   end

   uart_tx_arbiter_rr_pick #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .win_o (pick_win),
      .any_o (pick_any)
   );

   // The data path is a pure mux on the held grant; nothing here is registered.
   assign is_xfer       = (state_q == S_XFER);
   assign g_valid       = req_valid[grant_id_q];
   assign g_last        = req_last[grant_id_q];
   assign tx_data       = is_xfer ? req_byte[grant_id_q] : 8'h00;
   assign tx_data_valid = is_xfer && g_valid;
   assign accept        = tx_data_valid && tx_data_ready;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      byte_cnt_d    = byte_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      burst_cut_d   = 1'b0;
      stall_abort_d = 1'b0;
      rel_cause     = REL_NONE;

      case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               grant_id_d    = pick_win;
               grant_valid_d = 1'b1;
               byte_cnt_d    = '0;
               stall_cnt_d   = '0;
               state_d       = S_XFER;
            end
         end

         S_XFER: begin
            // A last-byte accept takes precedence over the burst limit.
            if (accept) begin
               stall_cnt_d = '0;
               if (g_last) begin
                  rel_cause = REL_LAST;
               end else if (byte_cnt_q == 16'(MAX_BURST - 1)) begin
                  rel_cause = REL_BURST;
               end else begin
                  byte_cnt_d = byte_cnt_q + 16'd1;
               end
            end else if (!g_valid) begin
               if (STALL_TIMEOUT != 0) begin
                  if (stall_cnt_q == STALL_W'(STALL_TIMEOUT - 1)) begin
                     rel_cause = REL_STALL;
                  end else begin
                     stall_cnt_d = stall_cnt_q + STALL_W'(1);
                  end
               end
            end else begin
               stall_cnt_d = '0;
            end

            if (rel_cause != REL_NONE) begin
               rr_ptr_d      = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
               byte_cnt_d    = '0;
               stall_cnt_d   = '0;
               gap_cnt_d     = '0;
               grant_valid_d = 1'b0;
               grant_id_d    = '0;
               burst_cut_d   = (rel_cause == REL_BURST);
               stall_abort_d = (rel_cause == REL_STALL);
               state_d       = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
            end
         end

         S_GAP: begin
            if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         byte_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         gap_cnt_q     <= '0;
         burst_cut_q   <= 1'b0;
         stall_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         byte_cnt_q    <= byte_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         burst_cut_q   <= burst_cut_d;
         stall_abort_q <= stall_abort_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign burst_cut   = burst_cut_q;
   assign stall_abort = stall_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level
// model of grant order, bytes per grant and release causes.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int MB  = 4;
   localparam int GAP = 5;
   localparam int STO = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_data_valid;
   logic           tx_data_ready;
   logic           grant_valid;
   logic [1:0]     grant_id;
   logic           burst_cut;
   logic           stall_abort;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ         (N),
      .MAX_BURST     (MB),
      .GAP_CYCLES    (GAP),
      .STALL_TIMEOUT (STO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .burst_cut     (burst_cut),
      .stall_abort   (stall_abort)
   );

   // Requester byte streams: {last, data}
   logic [8:0]   pkt_mem [N][32];
   int           head [N];
   int           tail [N];
   logic [N-1:0] acc_prev;
   int           busy;
   int           cyc;
   int           mdl_ptr;
   int           lim;

   // Expected grants from the packet-level model
   int           exp_id[$];
   int           exp_n[$];
   int           exp_kind[$];   // 0 last, 1 burst cut, 2 stall abort
   logic [7:0]   exp_bytes[$];

   int           g_idx, byte_pos, obs_n, low_run, idle_run, last_acc_cyc;
   bit           in_grant, have_rel, mon_en;
   int           n_checks = 0;
   int           n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_q();
      for (int k = 0; k < N; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic last);
      pkt_mem[r][tail[r]] = {last, d};
      tail[r]++;
   endtask

   function automatic bit all_empty();
      bit e = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (head[k] < tail[k]) e = 1'b0;
      end
      return e;
   endfunction

   // Packet-level reference: round-robin over non-empty streams, each grant
   // ends at last, after MB bytes, or when the stream runs dry (stall).
   task automatic build_expect();
      int  h [N];
      int  sel, n, kind, idx;
      bit  found, done;
      for (int k = 0; k < N; k++) h[k] = head[k];
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         sel   = 0;
         for (int k = 0; k < N; k++) begin
            idx = (mdl_ptr + k) % N;
            if (!found && h[idx] < tail[idx]) begin
               found = 1'b1;
               sel   = idx;
            end
         end
         if (found) begin
            n    = 0;
            kind = 2;
            done = 1'b0;
            while (!done && h[sel] < tail[sel]) begin
               exp_bytes.push_back(pkt_mem[sel][h[sel]][7:0]);
               n++;
               if (pkt_mem[sel][h[sel]][8]) begin
                  kind = 0;
                  done = 1'b1;
               end else if (n == MB) begin
                  kind = 1;
                  done = 1'b1;
               end
               h[sel]++;
            end
            exp_id.push_back(sel);
            exp_n.push_back(n);
            exp_kind.push_back(kind);
            mdl_ptr = (sel + 1) % N;
         end
      end
   endtask

   task automatic drive_reqs();
      for (int k = 0; k < N; k++) begin
         if (head[k] < tail[k]) begin
            req_valid[k]       = 1'b1;
            req_data[8*k +: 8] = pkt_mem[k][head[k]][7:0];
            req_last[k]        = pkt_mem[k][head[k]][8];
         end else begin
            req_valid[k]       = 1'b0;
            req_data[8*k +: 8] = 8'h00;
            req_last[k]        = 1'b0;
         end
      end
   endtask

   task automatic monitor();
      int          kind;
      logic [N-1:0] one = 1;
      if (in_grant && !grant_valid) begin
         kind = exp_kind[g_idx];
         chk("rel_bytes", obs_n, exp_n[g_idx]);
         chk("burst_cut", burst_cut, kind == 1);
         chk("stall_abort", stall_abort, kind == 2);
         if (kind == 2) chk("stall_len", low_run, STO);
         else           chk("rel_delay", cyc - last_acc_cyc, 1);
         $display("grant %0d: req=%0d bytes=%0d end_kind=%0d", g_idx, exp_id[g_idx], obs_n, kind);
         g_idx++;
         in_grant = 1'b0;
         have_rel = 1'b1;
         idle_run = 1;
      end else begin
         if (burst_cut || stall_abort) chk("stray_pulse", {burst_cut, stall_abort}, 0);
         if (!grant_valid) begin
            idle_run++;
            chk("idle_outputs", {tx_data_valid, req_ready, grant_id}, 0);
         end else begin
            if (!in_grant) begin
               if (g_idx < exp_id.size()) begin
                  chk("grant_id", grant_id, exp_id[g_idx]);
                  if (have_rel) chk("gap_len", idle_run, GAP + 1);
                  in_grant = 1'b1;
                  obs_n    = 0;
                  low_run  = 0;
               end else begin
                  chk("extra_grant", grant_valid, 0);
               end
            end
            if (in_grant) begin
               chk("ready_mask", req_ready, tx_data_ready ? (one << exp_id[g_idx]) : '0);
               if (!tx_data_valid) low_run++;
               else                low_run = 0;
               if (tx_data_valid && tx_data_ready) begin
                  chk("hold_id", grant_id, exp_id[g_idx]);
                  if (byte_pos < exp_bytes.size()) chk("tx_data", tx_data, exp_bytes[byte_pos]);
                  else                             chk("extra_byte", tx_data_valid, 0);
                  byte_pos++;
                  obs_n++;
                  last_acc_cyc = cyc;
               end
            end
         end
      end
   endtask

   // One clock: requesters and usart model update on the falling edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (acc_prev[k]) head[k]++;
      end
      tx_data_ready = (busy == 0);
      if (busy > 0) busy--;
      drive_reqs();
      #1;
      if (mon_en) monitor();
      acc_prev = req_valid & req_ready;
      if (tx_data_valid && tx_data_ready) busy = $urandom_range(1, 3);
   endtask

   // Asserted between clock edges so the async path is observed clock-free.
   task automatic do_reset();
      #1;
      rst           = 1'b1;
      req_valid     = '0;
      req_last      = '0;
      req_data      = '0;
      acc_prev      = '0;
      busy          = 0;
      tx_data_ready = 1'b1;
      #1;
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_burst_cut", burst_cut, 0);
      chk("rst_stall_abort", stall_abort, 0);
      chk("rst_tx_valid", tx_data_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_data", tx_data, 0);
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      mdl_ptr = 0;
   endtask

   task automatic run_phase(input string name);
      int n;
      build_expect();
      g_idx    = 0;
      byte_pos = 0;
      in_grant = 1'b0;
      have_rel = 1'b0;
      idle_run = 0;
      mon_en   = 1'b1;
      n        = 0;
      while (!(g_idx == exp_id.size() && !grant_valid && all_empty()) && n < 3000) begin
         step();
         n++;
      end
      repeat (2) step();
      if (n >= 3000) chk({name, "_timeout"}, n, 0);
      chk({name, "_grants"}, g_idx, exp_id.size());
      chk({name, "_bytes"}, byte_pos, exp_bytes.size());
      mon_en = 1'b0;
      exp_id.delete();
      exp_n.delete();
      exp_kind.delete();
      exp_bytes.delete();
   endtask

   initial begin
      int npk, len;
      rst           = 1'b0;
      req_valid     = '0;
      req_data      = '0;
      req_last      = '0;
      tx_data_ready = 1'b1;
      acc_prev      = '0;
      busy          = 0;
      cyc           = 0;
      mon_en        = 1'b0;
      mdl_ptr       = 0;
      clear_q();
      do_reset();

      // Single packet from requester 2, then rr_ptr=3 must favour requester 3 over 0
      push(2, 8'h41, 1'b0);
      push(2, 8'h42, 1'b1);
      run_phase("single");
      clear_q();
      push(0, 8'h10, 1'b1);
      push(3, 8'h13, 1'b1);
      run_phase("rr_ptr");

      // Fairness: every requester has two 1-byte packets
      do_reset();
      clear_q();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N; k++) push(k, 8'(16 * k + r), 1'b1);
      end
      run_phase("fair");

      // Burst limit: 6-byte packet from 0 while 1 waits
      do_reset();
      clear_q();
      for (int b = 1; b <= 6; b++) push(0, 8'(8'hA0 + b), b == 6);
      push(1, 8'hB1, 1'b1);
      run_phase("burst");

      // Stall: requester 1 sends one byte then goes quiet; 3 is pending
      clear_q();
      push(1, 8'h55, 1'b0);
      push(3, 8'h66, 1'b1);
      run_phase("stall");

      // Gap between two short packets
      clear_q();
      push(0, 8'h70, 1'b1);
      push(1, 8'h71, 1'b1);
      run_phase("gap");

      // Randomized packet mixes
      for (int rnd = 0; rnd < 6; rnd++) begin
         clear_q();
         for (int k = 0; k < N; k++) begin
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               len = $urandom_range(1, 7);
               for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
            end
         end
         run_phase("rand");
      end

      // Async reset during byte 2 of a 4-byte packet
      do_reset();
      clear_q();
      for (int b = 1; b <= 4; b++) push(0, 8'(8'hC0 + b), b == 4);
      push(2, 8'hD2, 1'b1);
      lim = 0;
      while (!(head[0] == 1 && grant_valid && tx_data_valid) && lim < 200) begin
         step();
         lim++;
      end
      chk("mid_pkt_reached", head[0], 1);
      do_reset();
      run_phase("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
